sram_axis_reader: RTL and testbench

- Drain engine on the AXI4 output side of sram_controller.
- On a start pulse it streams `length` consecutive words from one SRAM bank, starting at `base_addr`, through the controller's sram_out_* read port.
- Words leave as an AXI4-Stream master with TLAST on the final beat.
- Full 1-beat/cycle throughput while TREADY stays high; lossless under arbitrary backpressure.

---
 rtl/sram_axis_reader_pkg.sv | 16 +
 rtl/sram_rd_fifo.sv | 60 ++++++
 rtl/sram_axis_reader.sv | 164 ++++++++++++++++
 tb/tb_sram_axis_reader.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axis_reader_pkg.sv
// Shared constants and FSM state encoding for the SRAM-to-AXI4-Stream drain engine.
package sram_axis_reader_pkg;

    localparam int unsigned MAX_ADDR_WIDTH = 10;
    localparam int unsigned NUM_SRAMS      = 4;
    localparam int unsigned SRAM_WIDTH_O   = 16;
    localparam int unsigned INT8_SIZE      = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_READ,
        RD_DRAIN,
        RD_FIN
    } rd_state_t;

endpackage

// File: rtl/sram_rd_fifo.sv
// Two-entry first-word-fall-through register FIFO buffering SRAM read data.
module sram_rd_fifo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= din;
                    else             tail <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps the count; new word lands behind the survivor.
                    if (cnt == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head;
    assign empty = (cnt == 2'd0);
    assign full  = (cnt == 2'd2);
    assign count = cnt;

endmodule

// File: rtl/sram_axis_reader.sv
// Streams `length` words from one SRAM bank out as an AXI4-Stream master with TLAST.
// Optional signed saturation of read data: define SRAM_AXIS_READER_SAT_EN.
module sram_axis_reader
    import sram_axis_reader_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 8,
    parameter int unsigned MAX_ADDR_WIDTH     = sram_axis_reader_pkg::MAX_ADDR_WIDTH,
    parameter int unsigned NUM_SRAMS          = sram_axis_reader_pkg::NUM_SRAMS,
    parameter int unsigned SRAM_WIDTH_O       = sram_axis_reader_pkg::SRAM_WIDTH_O
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NUM_SRAMS-1:0]          src_idx,
    input  logic [MAX_ADDR_WIDTH-1:0]     base_addr,
    input  logic [MAX_ADDR_WIDTH:0]       length,
    output logic                          sram_out_en,
    output logic [NUM_SRAMS-1:0]          sram_out_idx,
    output logic [MAX_ADDR_WIDTH-1:0]     sram_out_addr,
    input  logic [SRAM_WIDTH_O-1:0]       sram_out_data,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          busy,
    output logic                          done
);

    localparam logic [MAX_ADDR_WIDTH-1:0] ADDR_ONE = MAX_ADDR_WIDTH'(1);
    localparam logic [MAX_ADDR_WIDTH:0]   CNT_ONE  = (MAX_ADDR_WIDTH + 1)'(1);

    rd_state_t state;
    rd_state_t state_next;

    logic [MAX_ADDR_WIDTH:0]       len_q;
    logic [MAX_ADDR_WIDTH:0]       req_cnt;
    logic [MAX_ADDR_WIDTH:0]       beat_cnt;
    logic [MAX_ADDR_WIDTH:0]       last_idx;
    logic [MAX_ADDR_WIDTH-1:0]     addr_q;
    logic [C_AXIS_TDATA_WIDTH-1:0] fifo_din;
    logic [C_AXIS_TDATA_WIDTH-1:0] fifo_dout;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [1:0]                    fifo_count;
    logic [2:0]                    occ;
    logic                          inflight;
    logic                          pop;
    logic                          room;
    logic                          accept;
    logic                          issue;

    // The registered request is the in-flight flag: its data is captured at the end of that cycle.
    assign inflight = sram_out_en;
    assign pop      = m_axis_tvalid & m_axis_tready;
    assign occ      = {1'b0, fifo_count} + {2'b00, inflight};
    assign room     = occ < (3'd2 + {2'b00, pop});
    assign last_idx = len_q - CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) state <= RD_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            RD_IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0) begin
                        state_next = RD_FIN;
                    end else begin
                        state_next = RD_READ;
                        issue      = 1'b1;
                    end
                end
            end
            RD_READ: begin
                if (req_cnt == len_q) state_next = RD_DRAIN;
                else                  issue      = room;
            end
            RD_DRAIN: begin
                if (pop && m_axis_tlast) state_next = RD_FIN;
            end
            RD_FIN:  state_next = RD_IDLE;
            default: state_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_out_en   <= 1'b0;
            sram_out_idx  <= '0;
            sram_out_addr <= '0;
            addr_q        <= '0;
            len_q         <= '0;
            req_cnt       <= '0;
            beat_cnt      <= '0;
            done          <= 1'b0;
        end else begin
            sram_out_en <= issue;
            done        <= (state == RD_FIN);
            if (accept) begin
                sram_out_idx  <= src_idx;
                sram_out_addr <= base_addr;
                addr_q        <= base_addr + ADDR_ONE;
                len_q         <= length;
                req_cnt       <= (length == '0) ? '0 : CNT_ONE;
                beat_cnt      <= '0;
            end else begin
                if (issue) begin
                    sram_out_addr <= addr_q;
                    addr_q        <= addr_q + ADDR_ONE;
                    req_cnt       <= req_cnt + CNT_ONE;
                end
                if (pop) beat_cnt <= beat_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(fifo_full && inflight && !pop));
    end

`ifdef SRAM_AXIS_READER_SAT_EN
    localparam int unsigned EXT = SRAM_WIDTH_O - C_AXIS_TDATA_WIDTH + 1;
    localparam logic signed [SRAM_WIDTH_O-1:0] SAT_MAX =
        {{EXT{1'b0}}, {(C_AXIS_TDATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SRAM_WIDTH_O-1:0] SAT_MIN =
        {{EXT{1'b1}}, {(C_AXIS_TDATA_WIDTH - 1){1'b0}}};

    always_comb begin
        fifo_din = sram_out_data[C_AXIS_TDATA_WIDTH-1:0];
        if ($signed(sram_out_data) > SAT_MAX)
            fifo_din = {1'b0, {(C_AXIS_TDATA_WIDTH - 1){1'b1}}};
        else if ($signed(sram_out_data) < SAT_MIN)
            fifo_din = {1'b1, {(C_AXIS_TDATA_WIDTH - 1){1'b0}}};
    end
`else
    assign fifo_din = sram_out_data[C_AXIS_TDATA_WIDTH-1:0];
`endif

    sram_rd_fifo #(
        .WIDTH(C_AXIS_TDATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = fifo_dout;
    assign m_axis_tlast  = !fifo_empty && (beat_cnt == last_idx);
    assign busy          = (state != RD_IDLE);

endmodule

// File: tb/tb_sram_axis_reader.sv
// Directed, self-checking bench for sram_axis_reader with a combinational SRAM bank model.
module tb_sram_axis_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  src_idx = '0;
    logic [3:0]  base_addr = '0;
    logic [4:0]  length = '0;
    logic        sram_out_en;
    logic [3:0]  sram_out_idx;
    logic [3:0]  sram_out_addr;
    logic [15:0] sram_out_data;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;

    logic [15:0] mem [16][16];

    int checks = 0;
    int errors = 0;

    logic [7:0] beat_q[$];
    logic       last_q[$];
    logic [3:0] addr_q[$];

    typedef struct {
        logic       poke;
        logic       en;
        logic [3:0] addr;
        logic       tvalid;
        logic [7:0] tdata;
        logic       tlast;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[12];

    sram_axis_reader #(
        .C_AXIS_TDATA_WIDTH(8),
        .MAX_ADDR_WIDTH(4),
        .NUM_SRAMS(4),
        .SRAM_WIDTH_O(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .src_idx       (src_idx),
        .base_addr     (base_addr),
        .length        (length),
        .sram_out_en   (sram_out_en),
        .sram_out_idx  (sram_out_idx),
        .sram_out_addr (sram_out_addr),
        .sram_out_data (sram_out_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Controller returns the addressed word while the registered request is up.
    assign sram_out_data = sram_out_en ? mem[sram_out_idx][sram_out_addr] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},     sram_out_en,   0);
        check({tag, "_idx"},    sram_out_idx,  0);
        check({tag, "_addr"},   sram_out_addr, 0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_tlast"},  m_axis_tlast,  0);
        check({tag, "_tdata"},  m_axis_tdata,  0);
        check({tag, "_busy"},   busy,          0);
        check({tag, "_done"},   done,          0);
    endtask

    // mode 0: tready always high; mode 1: tready pattern 1,0,0 repeating.
    task automatic run_xfer(input logic [3:0] bank, input logic [3:0] base, input logic [4:0] len,
                            input int mode, output int done_cyc);
        int   reqs;
        int   beats;
        logic prev_stall;
        logic [7:0] prev_data;
        logic prev_last;
        logic got_done;
        beat_q.delete();
        last_q.delete();
        addr_q.delete();
        reqs = 0;
        beats = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        got_done = 1'b0;
        done_cyc = -1;
        start = 1'b1;
        src_idx = bank;
        base_addr = base;
        length = len;
        m_axis_tready = 1'b1;
        for (int c = 1; c <= 200 && !got_done; c++) begin
            tick();
            start = 1'b0;
            m_axis_tready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (sram_out_en) begin
                reqs++;
                addr_q.push_back(sram_out_addr);
            end
            if (prev_stall) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", m_axis_tlast, prev_last);
            end
            check("occupancy_le2", (reqs - beats) <= 2, 1);
            if (m_axis_tvalid && m_axis_tready) begin
                beat_q.push_back(m_axis_tdata);
                last_q.push_back(m_axis_tlast);
                beats++;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_last = m_axis_tlast;
            if (done) begin
                got_done = 1'b1;
                done_cyc = c;
            end
        end
        if (!got_done) check("done_timeout", 0, 1);
        m_axis_tready = 1'b0;
    endtask

    task automatic check_beats(input string tag, input logic [7:0] exp [], input int n);
        check({tag, "_nbeats"}, beat_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, (i < beat_q.size()) ? beat_q[i] : 8'hxx, exp[i]);
            check({tag, "_last"}, (i < last_q.size()) ? last_q[i] : 1'bx, (i == n - 1));
        end
    endtask

    initial begin
        int         dc;
        int         nb;
        logic [7:0] exp [];

        for (int b = 0; b < 16; b++)
            for (int a = 0; a < 16; a++)
                mem[b][a] = 16'h0000;
        for (int i = 0; i < 8; i++) mem[2][i] = 16'(10 + i);
        mem[1][14] = 16'h0021;
        mem[1][15] = 16'h0022;
        mem[1][0]  = 16'h0023;
        mem[1][1]  = 16'h0024;
        mem[3][0]  = 16'd300;
        mem[3][1]  = 16'hFF38;
        mem[3][2]  = 16'd5;

        //          poke en addr tvalid tdata  tlast busy done
        tbl[0]  = '{0, 1, 4'd0, 0, 8'd0,  0, 1, 0};
        tbl[1]  = '{0, 1, 4'd1, 1, 8'd10, 0, 1, 0};
        tbl[2]  = '{0, 1, 4'd2, 1, 8'd11, 0, 1, 0};
        tbl[3]  = '{1, 1, 4'd3, 1, 8'd12, 0, 1, 0};
        tbl[4]  = '{0, 1, 4'd4, 1, 8'd13, 0, 1, 0};
        tbl[5]  = '{0, 1, 4'd5, 1, 8'd14, 0, 1, 0};
        tbl[6]  = '{0, 1, 4'd6, 1, 8'd15, 0, 1, 0};
        tbl[7]  = '{0, 1, 4'd7, 1, 8'd16, 0, 1, 0};
        tbl[8]  = '{0, 0, 4'd0, 1, 8'd17, 1, 1, 0};
        tbl[9]  = '{0, 0, 4'd0, 0, 8'd0,  0, 1, 0};
        tbl[10] = '{0, 0, 4'd0, 0, 8'd0,  0, 0, 1};
        tbl[11] = '{0, 0, 4'd0, 0, 8'd0,  0, 0, 0};

        tick();
        tick();
        rst = 1'b0;
        check_quiet("reset");

        // Basic stream, cycle by cycle; a start in row 3 arrives while busy.
        start = 1'b1;
        src_idx = 4'd2;
        base_addr = 4'd0;
        length = 5'd8;
        m_axis_tready = 1'b1;
        for (int r = 0; r < 12; r++) begin
            tick();
            start = tbl[r].poke;
            length = tbl[r].poke ? 5'd3 : 5'd8;
            check($sformatf("basic_en_c%0d", r + 1), sram_out_en, tbl[r].en);
            if (tbl[r].en) check($sformatf("basic_addr_c%0d", r + 1), sram_out_addr, tbl[r].addr);
            if (tbl[r].en) check($sformatf("basic_idx_c%0d", r + 1), sram_out_idx, 2);
            check($sformatf("basic_tvalid_c%0d", r + 1), m_axis_tvalid, tbl[r].tvalid);
            if (tbl[r].tvalid) check($sformatf("basic_tdata_c%0d", r + 1), m_axis_tdata, tbl[r].tdata);
            check($sformatf("basic_tlast_c%0d", r + 1), m_axis_tlast, tbl[r].tlast);
            check($sformatf("basic_busy_c%0d", r + 1), busy, tbl[r].busy);
            check($sformatf("basic_done_c%0d", r + 1), done, tbl[r].done);
        end
        start = 1'b0;
        m_axis_tready = 1'b0;

        // Backpressure.
        run_xfer(4'd2, 4'd0, 5'd8, 1, dc);
        exp = new[8];
        for (int i = 0; i < 8; i++) exp[i] = 8'(10 + i);
        check_beats("bp", exp, 8);

        // Zero length.
        start = 1'b1;
        src_idx = 4'd2;
        base_addr = 4'd3;
        length = 5'd0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            start = 1'b0;
            check($sformatf("zero_en_c%0d", c), sram_out_en, 0);
            check($sformatf("zero_tvalid_c%0d", c), m_axis_tvalid, 0);
            check($sformatf("zero_busy_c%0d", c), busy, (c == 1));
            check($sformatf("zero_done_c%0d", c), done, (c == 2));
        end

        // Address wrap.
        run_xfer(4'd1, 4'd14, 5'd4, 0, dc);
        check("wrap_nreq", addr_q.size(), 4);
        check("wrap_a0", (addr_q.size() > 0) ? addr_q[0] : 4'hx, 14);
        check("wrap_a1", (addr_q.size() > 1) ? addr_q[1] : 4'hx, 15);
        check("wrap_a2", (addr_q.size() > 2) ? addr_q[2] : 4'hx, 0);
        check("wrap_a3", (addr_q.size() > 3) ? addr_q[3] : 4'hx, 1);
        exp = new[4];
        exp[0] = 8'h21; exp[1] = 8'h22; exp[2] = 8'h23; exp[3] = 8'h24;
        check_beats("wrap", exp, 4);
        check("wrap_done_cycle", dc, 7);

        // Reset mid-transfer.
        start = 1'b1;
        src_idx = 4'd2;
        base_addr = 4'd0;
        length = 5'd8;
        m_axis_tready = 1'b1;
        nb = 0;
        for (int c = 0; c < 20 && nb < 3; c++) begin
            tick();
            start = 1'b0;
            if (m_axis_tvalid && m_axis_tready) nb++;
        end
        check("midrst_beats_seen", nb, 3);
        tick();
        rst = 1'b1;
        tick();
        check_quiet("midrst");
        rst = 1'b0;
        m_axis_tready = 1'b0;
        tick();
        run_xfer(4'd2, 4'd0, 5'd2, 0, dc);
        exp = new[2];
        exp[0] = 8'd10; exp[1] = 8'd11;
        check_beats("after_rst", exp, 2);

        // Wide words: saturation or truncation.
        run_xfer(4'd3, 4'd0, 5'd3, 0, dc);
        exp = new[3];
`ifdef SRAM_AXIS_READER_SAT_EN
        exp[0] = 8'h7F; exp[1] = 8'h80; exp[2] = 8'h05;
`else
        exp[0] = 8'h2C; exp[1] = 8'h38; exp[2] = 8'h05;
`endif
        check_beats("width", exp, 3);
        check("width_done_cycle", dc, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
